// File: rtl/cfg_write_arbiter.sv
// rtl/cfg_write_arbiter.sv - two-requester round-robin write arbiter for the PWM/output config bank
//
// Purpose:
//   Owns the five-register PWM/output configuration bank. Writes from the SPI
//   decoder (A) and the sequencer/loader (B) are arbitrated round-robin and
//   land in a shadow bank. The shadow is promoted to the active outputs either
//   on the same edge (commit_mode=0) or at the next PWM period boundary
//   (commit_mode=1), so the PWM generator never sees a mid-period change.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   a_valid/a_addr/a_data    requester A write request
//   a_ready                  requester A write accepted this cycle
//   b_valid/b_addr/b_data    requester B write request
//   b_ready                  requester B write accepted this cycle
//   commit_mode              0 = immediate commit, 1 = commit at period boundary
//   pwm_period_start         one-cycle pulse at PWM counter wrap
//   en_reg_out_7_0 ..        active registers 0..4
//   pwm_duty_cycle
//   commit_pending           shadow differs from active
//   addr_err                 pulse: an accepted write addressed a missing register

module cfg_write_arbiter #(
  parameter int ADDR_W   = 7,
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_valid,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_data,
  output logic              a_ready,
  input  logic              b_valid,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_data,
  output logic              b_ready,
  input  logic              commit_mode,
  input  logic              pwm_period_start,
  output logic [DATA_W-1:0] en_reg_out_7_0,
  output logic [DATA_W-1:0] en_reg_out_15_8,
  output logic [DATA_W-1:0] en_reg_pwm_7_0,
  output logic [DATA_W-1:0] en_reg_pwm_15_8,
  output logic [DATA_W-1:0] pwm_duty_cycle,
  output logic              commit_pending,
  output logic              addr_err
);

  typedef enum logic {
    ST_CLEAN = 1'b0,
    ST_DIRTY = 1'b1
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant_b;
  logic                r_addr_err;
  logic [DATA_W-1:0]   r_shadow [NUM_REGS];
  logic [DATA_W-1:0]   r_active [NUM_REGS];

  logic                w_grant_a;
  logic                w_grant_b;
  logic                w_accept;
  logic [ADDR_W-1:0]   w_addr;
  logic [DATA_W-1:0]   w_data;
  logic                w_addr_ok;
  logic                w_wr;
  logic                w_copy;
  logic [NUM_REGS-1:0] w_sel;

  // A wins when alone or when B had the last grant; B takes whatever A does not.
  always_comb begin
    w_grant_a = a_valid && (!b_valid || r_last_grant_b);
    w_grant_b = b_valid && !w_grant_a;
  end

  assign a_ready   = w_grant_a;
  assign b_ready   = w_grant_b;
  assign w_accept  = w_grant_a || w_grant_b;
  assign w_addr    = w_grant_b ? b_addr : a_addr;
  assign w_data    = w_grant_b ? b_data : a_data;
  assign w_addr_ok = (w_addr < ADDR_W'(NUM_REGS));
  assign w_wr      = w_accept && w_addr_ok;

  // Promotion happens from DIRTY either at the period boundary or as soon as
  // immediate mode is re-selected; the copy always sees pre-edge shadow values.
  assign w_copy = (r_state == ST_DIRTY) && (!commit_mode || pwm_period_start);

  always_comb begin
    w_sel = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      w_sel[i] = w_wr && (w_addr == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_CLEAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // A write accepted with the pulse leaves fresh shadow data, so DIRTY wins.
  always_comb begin
    w_state_nxt = r_state;
    if (!commit_mode) begin
      w_state_nxt = ST_CLEAN;
    end else if (w_wr) begin
      w_state_nxt = ST_DIRTY;
    end else if (pwm_period_start) begin
      w_state_nxt = ST_CLEAN;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_last_grant_b <= 1'b1;
      r_addr_err     <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        r_shadow[i] <= '0;
        r_active[i] <= '0;
      end
    end else begin
      r_addr_err <= w_accept && !w_addr_ok;
      if (w_accept) begin
        r_last_grant_b <= w_grant_b;
      end
      for (int i = 0; i < NUM_REGS; i++) begin
        if (w_sel[i]) begin
          r_shadow[i] <= w_data;
        end
        // An immediate-mode write overrides the bulk copy for its own register.
        if (w_sel[i] && !commit_mode) begin
          r_active[i] <= w_data;
        end else if (w_copy) begin
          r_active[i] <= r_shadow[i];
        end
      end
    end
  end

  assign en_reg_out_7_0  = r_active[0];
  assign en_reg_out_15_8 = r_active[1];
  assign en_reg_pwm_7_0  = r_active[2];
  assign en_reg_pwm_15_8 = r_active[3];
  assign pwm_duty_cycle  = r_active[4];
  assign commit_pending  = (r_state == ST_DIRTY);
  assign addr_err        = r_addr_err;

endmodule

// File: tb/tb_cfg_write_arbiter.sv
// tb/tb_cfg_write_arbiter.sv - self-checking bench for cfg_write_arbiter

module tb_cfg_write_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       a_valid = 1'b0;
  logic [6:0] a_addr = '0;
  logic [7:0] a_data = '0;
  logic       a_ready;
  logic       b_valid = 1'b0;
  logic [6:0] b_addr = '0;
  logic [7:0] b_data = '0;
  logic       b_ready;
  logic       commit_mode = 1'b0;
  logic       pwm_period_start = 1'b0;
  logic [7:0] en_reg_out_7_0;
  logic [7:0] en_reg_out_15_8;
  logic [7:0] en_reg_pwm_7_0;
  logic [7:0] en_reg_pwm_15_8;
  logic [7:0] pwm_duty_cycle;
  logic       commit_pending;
  logic       addr_err;

  int n_cmp = 0;
  int n_err = 0;

  // Behavioural model: register bank as arrays, dirty flag, grant memory.
  logic [7:0] m_sh  [5];
  logic [7:0] m_act [5];
  logic       m_dirty;
  logic       m_lg_b;
  logic       m_err;
  logic       m_gnt_a;
  logic       m_gnt_b;
  bit         chk_en = 1'b0;

  cfg_write_arbiter #(.ADDR_W(7), .DATA_W(8), .NUM_REGS(5)) dut (
    .clk              (clk),
    .rst              (rst),
    .a_valid          (a_valid),
    .a_addr           (a_addr),
    .a_data           (a_data),
    .a_ready          (a_ready),
    .b_valid          (b_valid),
    .b_addr           (b_addr),
    .b_data           (b_data),
    .b_ready          (b_ready),
    .commit_mode      (commit_mode),
    .pwm_period_start (pwm_period_start),
    .en_reg_out_7_0   (en_reg_out_7_0),
    .en_reg_out_15_8  (en_reg_out_15_8),
    .en_reg_pwm_7_0   (en_reg_pwm_7_0),
    .en_reg_pwm_15_8  (en_reg_pwm_15_8),
    .pwm_duty_cycle   (pwm_duty_cycle),
    .commit_pending   (commit_pending),
    .addr_err         (addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on every rising edge from the inputs the DUT sampled.
  initial forever begin
    logic       ga, gb, acc, ok;
    logic [6:0] ad;
    logic [7:0] dt;
    logic [7:0] old_sh [5];
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 5; i++) begin
        m_sh[i] = 8'h00;
        m_act[i] = 8'h00;
      end
      m_dirty = 1'b0;
      m_lg_b  = 1'b1;
      m_err   = 1'b0;
      m_gnt_a = 1'b0;
      m_gnt_b = 1'b0;
      chk_en  = 1'b1;
    end else begin
      ga  = a_valid && (!b_valid || m_lg_b);
      gb  = b_valid && !ga;
      acc = ga || gb;
      ad  = gb ? b_addr : a_addr;
      dt  = gb ? b_data : a_data;
      ok  = acc && (int'(ad) < 5);
      m_gnt_a = ga;
      m_gnt_b = gb;
      m_err   = acc && !ok;
      if (acc) m_lg_b = gb;
      for (int i = 0; i < 5; i++) old_sh[i] = m_sh[i];
      if (m_dirty && (!commit_mode || pwm_period_start)) begin
        for (int i = 0; i < 5; i++) m_act[i] = old_sh[i];
      end
      if (ok) begin
        m_sh[ad] = dt;
        if (!commit_mode) m_act[ad] = dt;
      end
      m_dirty = commit_mode && (ok || (m_dirty && !pwm_period_start));
    end
  end

  // Compare process: inputs were driven at negedge+1, so at negedge+3 the
  // readies reflect the upcoming edge and registered outputs the last one.
  initial forever begin
    logic exp_a, exp_b;
    @(negedge clk);
    #3;
    if (chk_en) begin
      exp_a = a_valid && (!b_valid || m_lg_b);
      exp_b = b_valid && !exp_a;
      check("a_ready", a_ready, exp_a);
      check("b_ready", b_ready, exp_b);
      check("reg0", en_reg_out_7_0, m_act[0]);
      check("reg1", en_reg_out_15_8, m_act[1]);
      check("reg2", en_reg_pwm_7_0, m_act[2]);
      check("reg3", en_reg_pwm_15_8, m_act[3]);
      check("reg4", pwm_duty_cycle, m_act[4]);
      check("commit_pending", commit_pending, m_dirty);
      check("addr_err", addr_err, m_err);
    end
  end

  task automatic cyc(input logic av, input logic [6:0] aa, input logic [7:0] ad,
                     input logic bv, input logic [6:0] ba, input logic [7:0] bd,
                     input logic cm, input logic ps, input logic rs);
    @(negedge clk);
    #1;
    a_valid = av; a_addr = aa; a_data = ad;
    b_valid = bv; b_addr = ba; b_data = bd;
    commit_mode = cm; pwm_period_start = ps; rst = rs;
  endtask

  task automatic idle(input logic cm);
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, cm, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic cm);
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, cm, 1'b0, 1'b1);
  endtask

  initial begin
    do_reset(1'b0);
    idle(1'b0);
    check("rst_reg4", pwm_duty_cycle, 8'h00);
    check("rst_pending", commit_pending, 1'b0);
    check("rst_addr_err", addr_err, 1'b0);

    // Immediate commit
    cyc(1'b1, 7'd4, 8'h80, 1'b0, 7'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    #1 check("imm_a_ready", a_ready, 1'b1);
    idle(1'b0);
    check("imm_duty", pwm_duty_cycle, 8'h80);
    check("imm_pending", commit_pending, 1'b0);
    check("model_duty", m_act[4], 8'h80);

    // Round-robin tie after reset: A,B,A,B
    do_reset(1'b0);
    for (int i = 0; i < 4; i++) begin
      cyc(1'b1, 7'd0, 8'h11, 1'b1, 7'd1, 8'h22, 1'b0, 1'b0, 1'b0);
      #1;
      check("rr_a_ready", a_ready, (i % 2 == 0) ? 1'b1 : 1'b0);
      check("rr_b_ready", b_ready, (i % 2 == 1) ? 1'b1 : 1'b0);
    end
    idle(1'b0);
    check("rr_reg0", en_reg_out_7_0, 8'h11);
    check("rr_reg1", en_reg_out_15_8, 8'h22);

    // Deferred commit
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd2, 8'hF0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd3, 8'h0F, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("def_reg2_hold", en_reg_pwm_7_0, 8'h00);
    check("def_reg3_hold", en_reg_pwm_15_8, 8'h00);
    check("def_pending", commit_pending, 1'b1);
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("def_reg2", en_reg_pwm_7_0, 8'hF0);
    check("def_reg3", en_reg_pwm_15_8, 8'h0F);
    check("def_clean", commit_pending, 1'b0);
    check("model_reg3", m_act[3], 8'h0F);

    // Write coinciding with the period pulse
    cyc(1'b0, 7'd0, 8'h00, 1'b1, 7'd2, 8'hAA, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 7'd2, 8'h55, 1'b0, 7'd0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("coin_reg2", en_reg_pwm_7_0, 8'hAA);
    check("coin_pending", commit_pending, 1'b1);
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("coin_reg2_next", en_reg_pwm_7_0, 8'h55);
    check("coin_clean", commit_pending, 1'b0);

    // Invalid address
    cyc(1'b1, 7'd7, 8'hFF, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    #1 check("bad_a_ready", a_ready, 1'b1);
    idle(1'b1);
    check("bad_addr_err", addr_err, 1'b1);
    check("bad_reg2", en_reg_pwm_7_0, 8'h55);
    check("bad_pending", commit_pending, 1'b0);
    idle(1'b1);
    check("bad_err_pulse", addr_err, 1'b0);

    // Falling commit_mode while DIRTY flushes the shadow
    cyc(1'b1, 7'd0, 8'h33, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("fall_reg0_hold", en_reg_out_7_0, 8'h11);
    check("fall_pending", commit_pending, 1'b1);
    idle(1'b0);
    idle(1'b0);
    check("fall_reg0", en_reg_out_7_0, 8'h33);
    check("fall_clean", commit_pending, 1'b0);

    // Reset discards a pending shadow
    cyc(1'b1, 7'd4, 8'h40, 1'b0, 7'd0, 8'h00, 1'b1, 1'b0, 1'b0);
    idle(1'b1);
    check("rstd_pending", commit_pending, 1'b1);
    do_reset(1'b1);
    cyc(1'b0, 7'd0, 8'h00, 1'b0, 7'd0, 8'h00, 1'b1, 1'b1, 1'b0);
    idle(1'b1);
    check("rstd_reg0", en_reg_out_7_0, 8'h00);
    check("rstd_reg2", en_reg_pwm_7_0, 8'h00);
    check("rstd_reg4", pwm_duty_cycle, 8'h00);
    check("rstd_pending", commit_pending, 1'b0);
    cyc(1'b1, 7'd0, 8'h01, 1'b1, 7'd1, 8'h02, 1'b1, 1'b0, 1'b0);
    #1;
    check("rstd_tie_a", a_ready, 1'b1);
    check("rstd_tie_b", b_ready, 1'b0);

    // Randomized traffic; a requester holds its request until granted.
    begin
      logic       av, bv, cm;
      logic [6:0] aa, ba;
      logic [7:0] ad, bd;
      av = 1'b0; bv = 1'b0; cm = 1'b0;
      aa = '0; ba = '0; ad = '0; bd = '0;
      for (int n = 0; n < 3000; n++) begin
        if (!(av && !m_gnt_a)) begin
          av = ($urandom_range(0, 2) != 0);
          aa = 7'($urandom_range(0, 7));
          ad = 8'($urandom);
        end
        if (!(bv && !m_gnt_b)) begin
          bv = ($urandom_range(0, 2) != 0);
          ba = 7'($urandom_range(0, 7));
          bd = 8'($urandom);
        end
        if ($urandom_range(0, 15) == 0) cm = ~cm;
        cyc(av, aa, ad, bv, ba, bd, cm,
            ($urandom_range(0, 5) == 0), ($urandom_range(0, 99) == 0));
      end
    end
    idle(1'b0);
    idle(1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cfg_write_arbiter.md
Name: cfg_write_arbiter

Overview:
- Owns the PWM/output configuration register bank: out enables [15:0], PWM enables [15:0], duty cycle.
- Arbitrates write requests from two requesters:
  - requester A: SPI transaction decoder.
  - requester B: on-chip sequencer / power-on loader.
- Writes land in a shadow bank. Shadow is promoted to the active outputs either immediately or at the next PWM period boundary, so the PWM generator never sees a mid-period change.

Parameters:
- ADDR_W, 7, register address width.
- DATA_W, 8, register data width.
- NUM_REGS, 5, number of implemented registers (addresses 0..NUM_REGS-1).

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- a_valid  input  1  requester A write request
- a_addr  input  ADDR_W  requester A register address
- a_data  input  DATA_W  requester A write data
- a_ready  output  1  requester A write accepted this cycle
- b_valid  input  1  requester B write request
- b_addr  input  ADDR_W  requester B register address
- b_data  input  DATA_W  requester B write data
- b_ready  output  1  requester B write accepted this cycle
- commit_mode  input  1  0 = immediate commit, 1 = commit at period boundary
- pwm_period_start  input  1  one-cycle pulse at PWM counter wrap
- en_reg_out_7_0  output  8  active reg 0
- en_reg_out_15_8  output  8  active reg 1
- en_reg_pwm_7_0  output  8  active reg 2
- en_reg_pwm_15_8  output  8  active reg 3
- pwm_duty_cycle  output  8  active reg 4
- commit_pending  output  1  shadow differs from active (DIRTY state)
- addr_err  output  1  one-cycle pulse: an accepted write had address >= NUM_REGS

Behaviour:
- Reset (rst high at a clk edge):
  - all active and shadow registers = 0.
  - commit FSM = CLEAN; commit_pending = 0; addr_err = 0.
  - last_grant = B, so A wins the first tie.
  - Reset overrides any concurrent request or pulse.
- Handshake:
  - a_ready/b_ready are combinational from the valids and last_grant.
  - A write transfers when valid && ready on a clk edge.
  - At most one write is accepted per cycle.
  - Requesters hold addr/data stable while valid and not ready.
- Arbitration (round-robin):
  - Only one valid: that requester is granted.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates only on an accepted write.
  - No valids: neither ready asserted; last_grant is held.
- Shadow write:
  - Accepted write with addr < NUM_REGS: shadow[addr] <= data at that edge.
  - Accepted write with addr >= NUM_REGS: the write is consumed (ready asserted), shadow is unchanged, and addr_err pulses high the following cycle.
- Commit FSM, states CLEAN / DIRTY:
  - commit_mode=0:
    - each valid accepted write also updates the active register at the same edge, so the output changes 1 cycle after the transfer edge.
    - FSM stays CLEAN.
  - commit_mode=1:
    - a valid accepted write moves the FSM to DIRTY; active is untouched.
    - In DIRTY, pwm_period_start copies all shadow registers to active and returns the FSM to CLEAN.
  - Simultaneous accept and pwm_period_start, in DIRTY or CLEAN with commit_mode=1:
    - the copy uses shadow values from before the edge.
    - the new write lands in shadow and the FSM ends in DIRTY.
  - pwm_period_start in CLEAN: no effect.
  - commit_mode falls 1->0 while DIRTY: at the next edge, copy shadow to active and go to CLEAN. Any write accepted on that same edge is applied to both shadow and active.
  - Invalid-address writes never change FSM state.
- commit_pending = (state == DIRTY), registered.
- Mid-operation reset: pending shadow contents are discarded; no partial commit occurs.

Test Plan:
- commit_mode=0, A writes addr 4 data 0x80 → a_ready=1 that cycle; pwm_duty_cycle=0x80 next cycle; commit_pending stays 0.
- A and B both valid for 4 cycles (A: addr0 0x11; B: addr1 0x22), all accepted writes traced:
  - grants alternate A,B,A,B after reset.
  - final en_reg_out_7_0=0x11, en_reg_out_15_8=0x22.
  - the non-granted ready is low in every cycle.
- commit_mode=1, B writes addr2 0xF0, then addr3 0x0F:
  - active regs stay 0 and commit_pending=1.
  - on pwm_period_start, both update next cycle and commit_pending=0.
- commit_mode=1, DIRTY with shadow reg2=0xAA; A writes addr2 0x55 in the same cycle as pwm_period_start:
  - en_reg_pwm_7_0=0xAA and commit_pending stays 1.
  - the next pulse gives 0x55.
- A writes addr 7 data 0xFF → a_ready=1, addr_err pulses one cycle, all registers unchanged, FSM unchanged.
- commit_mode=1, write addr4 0x40 (DIRTY), then assert rst for 1 cycle, then a pwm_period_start pulse:
  - all outputs stay 0 and commit_pending=0.
  - first tie after reset is granted to A.
